// File: rtl/lcd_sequencer_if.sv
// lcd_sequencer_if
//   Bundles the host-side buffer/refresh signals and the handshake towards
//   the character-LCD write controller into one connection.
//   Signals:
//     char_wr_en, char_addr[4:0], char_data[7:0]  host buffer write
//     refresh                                     one-cycle re-stream request
//     busy, init_done                             sequencer status
//     ctrl_data[7:0], ctrl_rs, ctrl_write_start   transaction to LCD controller
//     ctrl_done                                   lcd_done from LCD controller
//   The slave modport is the sequencer's view; master is the environment's view.
interface lcd_sequencer_if;
  logic       char_wr_en;
  logic [4:0] char_addr;
  logic [7:0] char_data;
  logic       refresh;
  logic       busy;
  logic       init_done;
  logic [7:0] ctrl_data;
  logic       ctrl_rs;
  logic       ctrl_write_start;
  logic       ctrl_done;

  modport slave (
    input  char_wr_en, char_addr, char_data, refresh, ctrl_done,
    output busy, init_done, ctrl_data, ctrl_rs, ctrl_write_start
  );

  modport master (
    output char_wr_en, char_addr, char_data, refresh, ctrl_done,
    input  busy, init_done, ctrl_data, ctrl_rs, ctrl_write_start
  );
endinterface

// File: rtl/lcd_sequencer.sv
// lcd_sequencer
//   Command/character sequencer in front of a 16x2 HD44780 write controller.
//   Holds a 32-byte display buffer written by the host, runs the power-up
//   init command list once after reset, then streams both display lines.
//   A refresh re-streams the buffer (steps 4..37) without repeating init.
//   Ports:
//     clock   in  system clock
//     reset   in  synchronous, active-low reset
//     bus     lcd_sequencer_if.slave: host buffer writes, refresh, status,
//             and the data/rs/write_start/done handshake to the controller
module lcd_sequencer #(
  parameter int unsigned POWERUP_DELAY = 750000,
  parameter int unsigned CMD_DELAY     = 2000,
  parameter int unsigned CLEAR_DELAY   = 82000
) (
  input  logic            clock,
  input  logic            reset,
  lcd_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    POWERUP, LOAD, STROBE, ACK_LOW, ACK_HIGH, DELAY, IDLE
  } state_e;

  localparam logic [19:0] POWERUP_LAST = 20'(POWERUP_DELAY - 1);
  localparam logic [19:0] CMD_LAST     = 20'(CMD_DELAY - 1);
  localparam logic [19:0] CLEAR_LAST   = 20'(CLEAR_DELAY - 1);

  logic [7:0]  buf_q [32];
  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [5:0]  step_q, step_d;
  logic        pend_q, pend_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        ws_q, ws_d;
  logic        initDone_q, initDone_d;

  logic [7:0]  stepData;
  logic        stepRs;
  logic [4:0]  bufIdx;

  // Display buffer; host writes land in any state. A write in the same
  // cycle as the LOAD reading that entry sends the old value.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
    end else if (bus.char_wr_en) begin
      buf_q[bus.char_addr] <= bus.char_data;
    end
  end

  // Step list: 4 init commands, line-1 address + 16 chars,
  // line-2 address + 16 chars.
  always_comb begin
    stepData = 8'h00;
    stepRs   = 1'b0;
    bufIdx   = 5'd0;
    if (step_q < 6'd4) begin
      case (step_q[1:0])
        2'd0:    stepData = 8'h38;
        2'd1:    stepData = 8'h0C;
        2'd2:    stepData = 8'h01;
        default: stepData = 8'h06;
      endcase
    end else if (step_q == 6'd4) begin
      stepData = 8'h80;
    end else if (step_q <= 6'd20) begin
      bufIdx   = 5'(step_q - 6'd5);
      stepData = buf_q[bufIdx];
      stepRs   = 1'b1;
    end else if (step_q == 6'd21) begin
      stepData = 8'hC0;
    end else begin
      bufIdx   = 5'(step_q - 6'd6);
      stepData = buf_q[bufIdx];
      stepRs   = 1'b1;
    end
  end

  // Next-state logic. The delay counter restarts at zero on every state
  // entry; refresh requests arriving while busy merge into one pending flag.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 20'd1;
    step_d     = step_q;
    pend_d     = pend_q | bus.refresh;
    data_d     = data_q;
    rs_d       = rs_q;
    ws_d       = ws_q;
    initDone_d = initDone_q;
    case (state_q)
      POWERUP: begin
        if (cnt_q == POWERUP_LAST) begin
          state_d = LOAD;
          cnt_d   = 20'd0;
          step_d  = 6'd0;
        end
      end
      LOAD: begin
        data_d  = stepData;
        rs_d    = stepRs;
        ws_d    = 1'b1;
        state_d = STROBE;
        cnt_d   = 20'd0;
      end
      STROBE: begin
        // write_start was raised on entry; drop it after two cycles
        if (cnt_q == 20'd1) begin
          ws_d    = 1'b0;
          state_d = ACK_LOW;
          cnt_d   = 20'd0;
        end
      end
      ACK_LOW: begin
        // a done level still high from the previous byte must not count
        if (!bus.ctrl_done) begin
          state_d = ACK_HIGH;
          cnt_d   = 20'd0;
        end
      end
      ACK_HIGH: begin
        if (bus.ctrl_done) begin
          state_d = DELAY;
          cnt_d   = 20'd0;
        end
      end
      DELAY: begin
        if (cnt_q == ((step_q == 6'd2) ? CLEAR_LAST : CMD_LAST)) begin
          cnt_d = 20'd0;
          if (step_q == 6'd3) initDone_d = 1'b1;
          if (step_q == 6'd37) begin
            state_d = IDLE;
          end else begin
            step_d  = step_q + 6'd1;
            state_d = LOAD;
          end
        end
      end
      IDLE: begin
        cnt_d = 20'd0;
        if (bus.refresh || pend_q) begin
          pend_d  = 1'b0;
          step_d  = 6'd4;
          state_d = LOAD;
        end
      end
      default: begin
        state_d = POWERUP;
        cnt_d   = 20'd0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= POWERUP;
      cnt_q      <= 20'd0;
      step_q     <= 6'd0;
      pend_q     <= 1'b0;
      data_q     <= 8'h00;
      rs_q       <= 1'b0;
      ws_q       <= 1'b0;
      initDone_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      pend_q     <= pend_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
      ws_q       <= ws_d;
      initDone_q <= initDone_d;
    end
  end

  assign bus.busy             = (state_q != IDLE);
  assign bus.init_done        = initDone_q;
  assign bus.ctrl_data        = data_q;
  assign bus.ctrl_rs          = rs_q;
  assign bus.ctrl_write_start = ws_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer
//   Self-checking bench for lcd_sequencer with small delays. A behavioural
//   LCD controller answers each write_start; an expectation queue built
//   from the display model (init list, line addresses, shadow buffer)
//   is checked at every strobe for byte, rs, init_done and the gap from
//   the event that should release it.
module tb_lcd_sequencer;
  localparam int PD  = 10;
  localparam int CMD = 4;
  localparam int CLR = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  lcd_sequencer_if bus();

  lcd_sequencer #(
    .POWERUP_DELAY(PD),
    .CMD_DELAY(CMD),
    .CLEAR_DELAY(CLR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       rs;
    logic       initDone;
    int         gap;
  } exp_t;

  exp_t       expQ[$];
  exp_t       popped;
  logic [7:0] shadow[32];
  logic [7:0] obsLog[$];
  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;
  int refCyc      = 0;
  int staleCycles = 1;
  int strobeCount = 0;
  int highLen     = 0;
  logic [7:0] riseData;
  logic wsPrev   = 1'b0;
  logic ctrlPrev = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void pushExp(input logic [7:0] d, input logic rs, input logic initDone, input int gap);
    exp_t e;
    e.data = d; e.rs = rs; e.initDone = initDone; e.gap = gap;
    expQ.push_back(e);
  endfunction

  // Power-up command list; the byte after the clear command waits longer.
  function automatic void pushInit(input int firstGap);
    pushExp(8'h38, 1'b0, 1'b0, firstGap);
    pushExp(8'h0C, 1'b0, 1'b0, CMD + 2);
    pushExp(8'h01, 1'b0, 1'b0, CMD + 2);
    pushExp(8'h06, 1'b0, 1'b0, CLR + 2);
  endfunction

  // Both display lines: DDRAM address command then 16 characters each.
  function automatic void pushStream(input int firstGap);
    for (int line = 0; line < 2; line++) begin
      pushExp((line == 0) ? 8'h80 : 8'hC0, 1'b0, 1'b1, (line == 0) ? firstGap : CMD + 2);
      for (int col = 0; col < 16; col++)
        pushExp(shadow[line * 16 + col], 1'b1, 1'b1, CMD + 2);
    end
  endfunction

  function automatic void shadowReset();
    for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
  endfunction

  // Behavioural LCD controller: done drops some cycles after the start
  // edge, rises three cycles later; the rise is the delay reference.
  initial begin
    bus.ctrl_done = 1'b1;
    forever begin
      @(negedge clock);
      if (bus.ctrl_write_start && !ctrlPrev) begin
        repeat (staleCycles) @(negedge clock);
        bus.ctrl_done = 1'b0;
        repeat (3) @(negedge clock);
        bus.ctrl_done = 1'b1;
        refCyc = cyc;
      end
      ctrlPrev = bus.ctrl_write_start;
    end
  end

  // Compare process: every strobe against the expectation queue, plus
  // strobe width and data stability while write_start is high.
  always @(negedge clock) begin
    if (bus.ctrl_write_start && !wsPrev) begin
      strobeCount++;
      obsLog.push_back(bus.ctrl_data);
      riseData = bus.ctrl_data;
      highLen  = 1;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        popped = expQ.pop_front();
        checkOutput("ctrl_data", {24'd0, bus.ctrl_data}, {24'd0, popped.data});
        checkOutput("ctrl_rs", {31'd0, bus.ctrl_rs}, {31'd0, popped.rs});
        checkOutput("init_done_at_strobe", {31'd0, bus.init_done}, {31'd0, popped.initDone});
        checkOutput("strobe_gap", cyc - refCyc, popped.gap);
      end
    end else if (bus.ctrl_write_start) begin
      highLen++;
      checkOutput("data_stable_in_strobe", {24'd0, bus.ctrl_data}, {24'd0, riseData});
    end else if (wsPrev && reset) begin
      checkOutput("strobe_width", highLen, 2);
    end
    wsPrev = bus.ctrl_write_start;
  end

  task automatic applyStimulus(input logic wr, input logic [4:0] addr, input logic [7:0] data, input logic refr);
    @(negedge clock);
    bus.char_wr_en = wr;
    bus.char_addr  = addr;
    bus.char_data  = data;
    bus.refresh    = refr;
    if (wr) shadow[addr] = data;
    if (refr && !bus.busy) refCyc = cyc;
    @(negedge clock);
    bus.char_wr_en = 1'b0;
    bus.refresh    = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while ((expQ.size() != 0 || bus.busy) && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput({name, "_timeout"}, {31'd0, n >= budget}, 32'd0);
  endtask

  initial begin
    #400000;
    failCount++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    int base;
    int n;
    bus.char_wr_en = 1'b0;
    bus.char_addr  = 5'd0;
    bus.char_data  = 8'h00;
    bus.refresh    = 1'b0;
    shadowReset();

    // Reset state
    repeat (3) @(negedge clock);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd1);
    checkOutput("reset_init_done", {31'd0, bus.init_done}, 32'd0);
    checkOutput("reset_write_start", {31'd0, bus.ctrl_write_start}, 32'd0);
    checkOutput("reset_ctrl_data", {24'd0, bus.ctrl_data}, 32'd0);
    checkOutput("reset_ctrl_rs", {31'd0, bus.ctrl_rs}, 32'd0);

    // Full power-up init and first stream of the blank buffer
    pushInit(PD + 1);
    pushStream(CMD + 2);
    reset  = 1'b1;
    refCyc = cyc;
    waitDrain("first_init", 2000);
    checkOutput("init_done_after_init", {31'd0, bus.init_done}, 32'd1);
    checkOutput("busy_after_init", {31'd0, bus.busy}, 32'd0);
    checkOutput("first_init_count", strobeCount, 38);
    checkOutput("first_byte", {24'd0, obsLog[0]}, 32'h38);
    checkOutput("second_byte", {24'd0, obsLog[1]}, 32'h0C);
    checkOutput("third_byte", {24'd0, obsLog[2]}, 32'h01);
    checkOutput("fourth_byte", {24'd0, obsLog[3]}, 32'h06);

    // HELLO / Z then refresh from IDLE
    applyStimulus(1'b1, 5'd0, 8'h48, 1'b0);
    applyStimulus(1'b1, 5'd1, 8'h45, 1'b0);
    applyStimulus(1'b1, 5'd2, 8'h4C, 1'b0);
    applyStimulus(1'b1, 5'd3, 8'h4C, 1'b0);
    applyStimulus(1'b1, 5'd4, 8'h4F, 1'b0);
    applyStimulus(1'b1, 5'd31, 8'h5A, 1'b0);
    base = obsLog.size();
    pushStream(2);
    applyStimulus(1'b0, 5'd0, 8'h00, 1'b1);
    waitDrain("hello_refresh", 2000);
    checkOutput("hello_len", obsLog.size() - base, 34);
    if (obsLog.size() >= base + 34) begin
      checkOutput("hello_addr1", {24'd0, obsLog[base]}, 32'h80);
      checkOutput("hello_H", {24'd0, obsLog[base + 1]}, 32'h48);
      checkOutput("hello_O", {24'd0, obsLog[base + 5]}, 32'h4F);
      checkOutput("hello_space", {24'd0, obsLog[base + 6]}, 32'h20);
      checkOutput("hello_addr2", {24'd0, obsLog[base + 17]}, 32'hC0);
      checkOutput("hello_Z_last", {24'd0, obsLog[base + 33]}, 32'h5A);
    end

    // Stale done held high after each strobe; nothing may be skipped
    staleCycles = 5;
    pushStream(2);
    applyStimulus(1'b0, 5'd0, 8'h00, 1'b1);
    waitDrain("stale_done", 3000);
    staleCycles = 1;

    // Reset in the middle of step 10's strobe
    reset = 1'b0;
    shadowReset();
    repeat (3) @(negedge clock);
    reset  = 1'b1;
    refCyc = cyc;
    pushInit(PD + 1);
    pushStream(CMD + 2);
    n = 0;
    while (expQ.size() > 27 && n < 2000) begin
      @(negedge clock);
      #1;
      n++;
    end
    checkOutput("reach_step10_timeout", {31'd0, n >= 2000}, 32'd0);
    checkOutput("step10_strobe_high", {31'd0, bus.ctrl_write_start}, 32'd1);
    checkOutput("step10_init_done", {31'd0, bus.init_done}, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("abort_write_start", {31'd0, bus.ctrl_write_start}, 32'd0);
    checkOutput("abort_init_done", {31'd0, bus.init_done}, 32'd0);
    checkOutput("abort_busy", {31'd0, bus.busy}, 32'd1);
    repeat (5) @(negedge clock);
    expQ.delete();

    // Restarted init with three refreshes merging into one extra pass
    base = strobeCount;
    pushInit(PD + 1);
    pushStream(CMD + 2);
    pushStream(CMD + 3);
    reset  = 1'b1;
    refCyc = cyc;
    repeat (20) @(negedge clock);
    applyStimulus(1'b0, 5'd0, 8'h00, 1'b1);
    repeat (40) @(negedge clock);
    applyStimulus(1'b0, 5'd0, 8'h00, 1'b1);
    repeat (80) @(negedge clock);
    applyStimulus(1'b0, 5'd0, 8'h00, 1'b1);
    waitDrain("merged_refresh", 4000);
    checkOutput("merged_refresh_count", strobeCount - base, 72);

    // Quiet afterwards: no further pass, idle
    repeat (40) @(negedge clock);
    checkOutput("final_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("final_count", strobeCount - base, 72);
    checkOutput("final_init_done", {31'd0, bus.init_done}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
